// File: rtl/cbfp_stage.sv
// Convergent block floating point stage: gathers BEATS beats of LANES complex samples,
// finds the block-wide common left shift and replays the block normalised to DOUT_W bits.
module cbfp_stage #(
    parameter int LANES   = 16,
    parameter int DIN_W   = 23,
    parameter int DOUT_W  = 11,
    parameter int BLK_LEN = 64,
    parameter int EXP_W   = $clog2(DIN_W)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic                      norm_en,
    input  logic [LANES*DIN_W-1:0]    din_re,
    input  logic [LANES*DIN_W-1:0]    din_im,
    output logic                      valid_out,
    output logic [LANES*DOUT_W-1:0]   dout_re,
    output logic [LANES*DOUT_W-1:0]   dout_im,
    output logic [EXP_W-1:0]          blk_exp,
    output logic                      blk_last
);

    localparam int BEATS = BLK_LEN / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RND_W = DIN_W - DOUT_W;
    localparam logic [EXP_W-1:0]  RSC_MAX  = EXP_W'(DIN_W - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BEATS - 1);
    localparam logic [DOUT_W-1:0] POS_MAX  = {1'b0, {(DOUT_W-1){1'b1}}};

    // Ping-pong sample banks, indexed [bank][beat][lane]
    logic [DIN_W-1:0] bank_re [2][BEATS][LANES];
    logic [DIN_W-1:0] bank_im [2][BEATS][LANES];

    logic [CNT_W-1:0]  in_cnt;
    logic              in_bank;
    logic [EXP_W-1:0]  run_min;
    logic              blk_norm;

    logic              fin_pend;
    logic [EXP_W-1:0]  fin_min;
    logic              fin_norm;
    logic              fin_bank;

    logic              out_active;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_bank;
    logic [EXP_W-1:0]  sh;

    logic [EXP_W-1:0]  beat_min;
    logic [EXP_W-1:0]  blk_min_nxt;
    logic [EXP_W-1:0]  run_base;
    logic              norm_cur;
    logic              last_beat;
    logic [LANES*DOUT_W-1:0] nxt_re;
    logic [LANES*DOUT_W-1:0] nxt_im;

    function automatic logic [EXP_W-1:0] rsc(input logic [DIN_W-1:0] v);
        logic [EXP_W-1:0] n;
        logic             run;
        n   = '0;
        run = 1'b1;
        for (int unsigned i = 1; i < DIN_W; i++) begin
            if (run && (v[DIN_W-1-i] == v[DIN_W-1])) n = n + 1'b1;
            else run = 1'b0;
        end
        return n;
    endfunction

    // Shift, keep top DOUT_W bits plus the first dropped bit for round-half-up.
    // Only the positive maximum can overflow when the round bit is added.
    function automatic logic [DOUT_W-1:0] norm_sample(input logic [DIN_W-1:0] x,
                                                      input logic [EXP_W-1:0] s);
        logic [DOUT_W-1:0] top;
        logic              rb;
        {top, rb} = (DOUT_W+1)'((x << s) >> (RND_W - 1));
        if (top == POS_MAX) return top;
        return top + DOUT_W'(rb);
    endfunction

    always_comb begin
        beat_min = RSC_MAX;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (rsc(din_re[l*DIN_W +: DIN_W]) < beat_min) beat_min = rsc(din_re[l*DIN_W +: DIN_W]);
            if (rsc(din_im[l*DIN_W +: DIN_W]) < beat_min) beat_min = rsc(din_im[l*DIN_W +: DIN_W]);
        end
    end

    always_comb begin
        run_base    = (in_cnt == '0) ? RSC_MAX : run_min;
        blk_min_nxt = (beat_min < run_base) ? beat_min : run_base;
        norm_cur    = (in_cnt == '0) ? norm_en : blk_norm;
        last_beat   = valid_in && (in_cnt == CNT_LAST);
    end

    always_comb begin
        nxt_re = '0;
        nxt_im = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            nxt_re[l*DOUT_W +: DOUT_W] = norm_sample(bank_re[out_bank][out_cnt][l], sh);
            nxt_im[l*DOUT_W +: DOUT_W] = norm_sample(bank_im[out_bank][out_cnt][l], sh);
        end
    end

    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                bank_re[in_bank][in_cnt][l] <= din_re[l*DIN_W +: DIN_W];
                bank_im[in_bank][in_cnt][l] <= din_im[l*DIN_W +: DIN_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt     <= '0;
            in_bank    <= 1'b0;
            run_min    <= RSC_MAX;
            blk_norm   <= 1'b0;
            fin_pend   <= 1'b0;
            fin_min    <= '0;
            fin_norm   <= 1'b0;
            fin_bank   <= 1'b0;
            out_active <= 1'b0;
            out_cnt    <= '0;
            out_bank   <= 1'b0;
            sh         <= '0;
            valid_out  <= 1'b0;
            blk_last   <= 1'b0;
            blk_exp    <= '0;
            dout_re    <= '0;
            dout_im    <= '0;
        end else begin
            fin_pend <= last_beat;
            if (valid_in) begin
                if (in_cnt == '0) blk_norm <= norm_en;
                run_min <= blk_min_nxt;
                if (in_cnt == CNT_LAST) begin
                    in_cnt   <= '0;
                    in_bank  <= ~in_bank;
                    fin_min  <= blk_min_nxt;
                    fin_norm <= norm_cur;
                    fin_bank <= in_bank;
                end else begin
                    in_cnt <= in_cnt + 1'b1;
                end
            end

            valid_out <= out_active;
            blk_last  <= out_active && (out_cnt == CNT_LAST);
            blk_exp   <= out_active ? sh : '0;
            dout_re   <= out_active ? nxt_re : '0;
            dout_im   <= out_active ? nxt_im : '0;

            // A new block may start on the same edge the previous one emits its last beat;
            // that beat is computed from the old sh/bank, so the restart simply wins.
            if (fin_pend) begin
                sh         <= fin_norm ? fin_min : '0;
                out_bank   <= fin_bank;
                out_cnt    <= '0;
                out_active <= 1'b1;
            end else if (out_active) begin
                if (out_cnt == CNT_LAST) out_active <= 1'b0;
                else out_cnt <= out_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cbfp_stage.sv
// Randomised bench for cbfp_stage against an arithmetic block-floating-point model.
module tb_cbfp_stage;

    localparam int LANES   = 16;
    localparam int DIN_W   = 23;
    localparam int DOUT_W  = 11;
    localparam int BLK_LEN = 64;
    localparam int EXP_W   = 5;
    localparam int BEATS   = BLK_LEN / LANES;
    localparam int RND_W   = DIN_W - DOUT_W;
    localparam int CW      = 512;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     valid_in;
    logic                     norm_en;
    logic [LANES*DIN_W-1:0]   din_re;
    logic [LANES*DIN_W-1:0]   din_im;
    logic                     valid_out;
    logic [LANES*DOUT_W-1:0]  dout_re;
    logic [LANES*DOUT_W-1:0]  dout_im;
    logic [EXP_W-1:0]         blk_exp;
    logic                     blk_last;

    cbfp_stage #(
        .LANES   (LANES),
        .DIN_W   (DIN_W),
        .DOUT_W  (DOUT_W),
        .BLK_LEN (BLK_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .norm_en   (norm_en),
        .din_re    (din_re),
        .din_im    (din_im),
        .valid_out (valid_out),
        .dout_re   (dout_re),
        .dout_im   (dout_im),
        .blk_exp   (blk_exp),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [LANES*DOUT_W-1:0] re;
        logic [LANES*DOUT_W-1:0] im;
        logic [EXP_W-1:0]        ex;
        logic                    last;
        int                      due;
    } beat_t;

    beat_t expq[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    int cur_re [LANES];
    int cur_im [LANES];
    int blk_re [BEATS][LANES];
    int blk_im [BEATS][LANES];
    int m_cnt  = 0;
    bit m_norm = 1'b0;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Number of times v can be doubled while staying representable in DIN_W bits
    function automatic int rsc_of(input int v);
        longint lim = longint'(1) << (DIN_W - 1);
        int k = 0;
        while (k < DIN_W - 1 && longint'(v) * (longint'(1) << (k + 1)) < lim
                             && longint'(v) * (longint'(1) << (k + 1)) >= -lim)
            k++;
        return k;
    endfunction

    function automatic int out_of(input int v, input int sh);
        longint x = longint'(v) * (longint'(1) << sh);
        longint y = (x + (longint'(1) << (RND_W - 1))) >>> RND_W;
        longint mx = (longint'(1) << (DOUT_W - 1)) - 1;
        if (y > mx) y = mx;
        return int'(y);
    endfunction

    function automatic int rand_val(input int m);
        int span = 1 << m;
        return int'($urandom_range(2 * span - 1, 0)) - span;
    endfunction

    task automatic push_block(input int t_last);
        int sh = DIN_W - 1;
        beat_t b;
        for (int i = 0; i < BEATS; i++)
            for (int l = 0; l < LANES; l++) begin
                if (rsc_of(blk_re[i][l]) < sh) sh = rsc_of(blk_re[i][l]);
                if (rsc_of(blk_im[i][l]) < sh) sh = rsc_of(blk_im[i][l]);
            end
        if (!m_norm) sh = 0;
        for (int i = 0; i < BEATS; i++) begin
            for (int l = 0; l < LANES; l++) begin
                b.re[l*DOUT_W +: DOUT_W] = DOUT_W'(out_of(blk_re[i][l], sh));
                b.im[l*DOUT_W +: DOUT_W] = DOUT_W'(out_of(blk_im[i][l], sh));
            end
            b.ex   = EXP_W'(sh);
            b.last = (i == BEATS - 1);
            b.due  = t_last + 2 + i;
            expq.push_back(b);
        end
    endtask

    task automatic drive_beat(input bit v, input bit n);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        valid_in = v;
        norm_en  = n;
        for (int l = 0; l < LANES; l++) begin
            din_re[l*DIN_W +: DIN_W] = cur_re[l][DIN_W-1:0];
            din_im[l*DIN_W +: DIN_W] = cur_im[l][DIN_W-1:0];
        end
        if (v) begin
            if (m_cnt == 0) m_norm = n;
            for (int l = 0; l < LANES; l++) begin
                blk_re[m_cnt][l] = cur_re[l];
                blk_im[m_cnt][l] = cur_im[l];
            end
            if (m_cnt == BEATS - 1) begin
                push_block(cyc + 1);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic fill_const(input int v);
        for (int l = 0; l < LANES; l++) begin
            cur_re[l] = v;
            cur_im[l] = v;
        end
    endtask

    task automatic fill_rand(input int m);
        for (int l = 0; l < LANES; l++) begin
            cur_re[l] = rand_val(m);
            cur_im[l] = rand_val(m);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            fill_rand(22);
            drive_beat(1'b0, 1'($urandom_range(1, 0)));
        end
    endtask

    task automatic send_block(input int m, input bit n);
        for (int i = 0; i < BEATS; i++) begin
            fill_rand(m);
            drive_beat(1'b1, n);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        valid_in = 1'b0;
        // Beats due after the reset edge will never appear
        while (expq.size() > 0 && expq[$].due > cyc) void'(expq.pop_back());
        m_cnt = 0;
        repeat (n - 1) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_out) begin
                if (expq.size() == 0) begin
                    check("spurious_valid", CW'(valid_out), CW'(0));
                end else begin
                    beat_t b;
                    b = expq.pop_front();
                    check("beat_cycle", CW'(cyc), CW'(b.due));
                    check("dout_re", CW'(dout_re), CW'(b.re));
                    check("dout_im", CW'(dout_im), CW'(b.im));
                    check("blk_exp", CW'(blk_exp), CW'(b.ex));
                    check("blk_last", CW'(blk_last), CW'(b.last));
                end
            end else begin
                check("idle_zero", CW'({dout_re, dout_im, blk_exp, blk_last}), CW'(0));
                if (expq.size() > 0 && expq[0].due <= cyc) begin
                    check("missing_beat", CW'(valid_out), CW'(1));
                    void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        norm_en  = 1'b0;
        din_re   = '0;
        din_im   = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_state", CW'({valid_out, dout_re, dout_im, blk_exp, blk_last}), CW'(0));
        mon_en = 1'b1;

        // All-zero block: maximal shift
        fill_const(0);
        for (int i = 0; i < BEATS; i++) drive_beat(1'b1, 1'b1);
        idle(6);

        // Mixed magnitudes: +/-1024 and a small value that rounds up
        for (int i = 0; i < BEATS; i++) begin
            fill_const(0);
            if (i == 0) cur_re[3] = 1024;
            if (i == 1) cur_im[5] = 3;
            if (i == 2) cur_re[7] = -1024;
            drive_beat(1'b1, 1'b1);
        end
        idle(6);

        // Positive full-scale saturates; then norm_en sampled low on beat 0 only
        for (int i = 0; i < BEATS; i++) begin
            fill_const(0);
            if (i == 0) cur_re[0] = 4194303;
            drive_beat(1'b1, 1'b1);
        end
        for (int i = 0; i < BEATS; i++) begin
            fill_const(0);
            if (i == 1) cur_re[2] = 4096;
            drive_beat(1'b1, i != 0);
        end
        idle(6);

        // Three blocks back to back at full rate
        send_block(5, 1'b1);
        send_block(15, 1'b1);
        send_block(21, 1'b1);
        idle(8);

        // Gapped delivery 1,0,0,1,1,0,1
        begin
            bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
            for (int i = 0; i < 7; i++) begin
                fill_rand(10);
                drive_beat(pat[i], 1'b1);
            end
        end
        idle(6);

        // Partial block discarded by reset, then a clean small block
        fill_rand(22); drive_beat(1'b1, 1'b1);
        fill_rand(22); drive_beat(1'b1, 1'b1);
        do_reset(2);
        send_block(4, 1'b1);
        idle(6);

        // Reset in the middle of an output burst
        send_block(12, 1'b1);
        idle(3);
        do_reset(2);
        idle(6);

        // Random traffic
        for (int k = 0; k < 30; k++) begin
            int m = int'($urandom_range(22, 0));
            bit n = 1'($urandom_range(3, 0) != 0);
            int sent = 0;
            while (sent < BEATS) begin
                if ($urandom_range(9, 0) < 7) begin
                    fill_rand(m);
                    drive_beat(1'b1, n);
                    sent++;
                end else begin
                    idle(1);
                end
            end
        end

        for (int i = 0; i < 20 && expq.size() > 0; i++) idle(1);
        idle(2);
        check("drain", CW'(expq.size()), CW'(0));
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbfp_stage.md
CBFP_STAGE -- requirements
Module: cbfp_stage

Interface
REQ-001 Parameter LANES, default 16, parallel complex samples per beat.
REQ-002 Parameter DIN_W, default 23, input sample width (signed two's complement).
REQ-003 Parameter DOUT_W, default 11, output sample width (signed), DOUT_W < DIN_W.
REQ-004 Parameter BLK_LEN, default 64, samples per block; BLK_LEN multiple of LANES; BEATS = BLK_LEN/LANES (default 4).
REQ-005 Derived EXP_W = clog2(DIN_W), default 5.
REQ-006 Port list:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- valid_in  in  1  input beat qualifier
- norm_en  in  1  1 = block normalisation, 0 = fixed shift 0
- din_re  in  LANES x DIN_W  real parts, signed
- din_im  in  LANES x DIN_W  imaginary parts, signed
- valid_out  out  1  output beat qualifier
- dout_re  out  LANES x DOUT_W  normalised real parts, signed
- dout_im  out  LANES x DOUT_W  normalised imaginary parts, signed
- blk_exp  out  EXP_W  shift applied to the block currently on the outputs
- blk_last  out  1  high on the final output beat of a block

Function
REQ-007 Block assembly: each valid_in=1 cycle is one beat; a beat counter 0..BEATS-1 advances only on valid_in; valid_in=0 gaps inside a block are allowed and do not advance the counter.
REQ-008 norm_en is sampled on beat 0 and held for the whole block.
REQ-009 Per sample, redundant sign count rsc = number of bits directly below the MSB that equal the MSB (range 0..DIN_W-1); a value of 0 or -1 yields DIN_W-1.
REQ-010 Block shift sh = minimum rsc over all LANES x BEATS re and im samples of the block if norm_en=1, else 0.
REQ-011 Storage: two ping-pong banks of BEATS x LANES complex samples; block k writes bank k mod 2.
REQ-012 If the last input beat is sampled at edge T, sh is registered at T+1 and output beats 0..BEATS-1 appear on edges T+2..T+1+BEATS with valid_out=1, one beat per cycle, no gaps.
REQ-013 Output beat i carries the samples of input beat i of the same block, in the same lane order.
REQ-014 Output arithmetic per component: s = din <<< sh (DIN_W bits); y = s[DIN_W-1 : DIN_W-DOUT_W] + s[DIN_W-DOUT_W-1] (round half up); saturate to 2^(DOUT_W-1)-1 on positive overflow.
REQ-015 blk_exp = sh for every beat of the block; blk_last=1 only on output beat BEATS-1.
REQ-016 When valid_out=0, dout_re, dout_im, blk_exp and blk_last are held at 0.
REQ-017 Back-to-back blocks at full rate (valid_in=1 every cycle) are accepted with no stall or loss; block k+1 output follows block k output with no idle cycle.
REQ-018 Simultaneous last-input-beat of block k+1 and output of block k from the other bank: both proceed; no bank conflict.
REQ-019 Beat counter wraps BEATS-1 -> 0 on a valid beat; bank select toggles on the same edge.

Reset
REQ-020 rst=1 at an edge clears beat counter, bank select, running minimum (to DIN_W-1), pending-output state; valid_out, blk_last, blk_exp, dout_re, dout_im = 0 from the next edge.
REQ-021 rst mid-block discards the partial block; rst during output aborts the remaining output beats; the first valid_in after rst release is beat 0 of a new block.
REQ-022 Bank contents need not be cleared by reset.

Verification
REQ-023 Defaults, norm_en=1, one block of all zeros, full rate -> valid_out high 4 cycles starting 2 cycles after last input beat; all dout 0; blk_exp=22; blk_last on 4th beat.
REQ-024 Block with max |sample| re=1024, one re=-1024, one im=3, rest 0 -> blk_exp=11; 1024 -> 512, -1024 -> -512, 3 -> 2 (rounded).
REQ-025 Block containing re=4194303, norm_en=1 -> blk_exp=0; that output = 1023 (saturated); with norm_en=0 and sample 4096 -> blk_exp=0, output 1.
REQ-026 Three blocks back to back at full rate, different magnitudes -> 12 consecutive valid_out cycles, each block with its own blk_exp, blk_last every 4th cycle, data order preserved.
REQ-027 Block delivered with valid_in gaps (pattern 1,0,0,1,1,0,1) -> output identical to gap-free delivery, timed from the last valid beat.
REQ-028 rst asserted after 2 beats of a block, then a full clean block -> only the clean block is output; its blk_exp ignores the discarded beats.
